addsub_share_arbiter: RTL and testbench

//  Shares a single rippleSubAdder instance (add/sub slice, D=1 -> A-B) between NREQ requesters.

---
 rtl/addsub_share_arbiter_if.sv | 53 +++++
 rtl/addsub_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_addsub_share_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/addsub_share_arbiter_if.sv
// addsub_share_arbiter_if
//   Bundles the request and response channels of addsub_share_arbiter.
//   Handshake: a transfer happens on a channel in every cycle where both
//   its valid and its ready are high. A requester keeps req_valid[i] and
//   its operands stable until req_ready[i] is seen. The arbiter keeps
//   rsp_* stable while rsp_valid is high and rsp_ready is low.
//   Signals:
//     req_valid  NREQ    requester i has an operation pending
//     req_ready  NREQ    one-hot grant from the arbiter
//     req_a      NREQ*N  operand A, requester i in [i*N +: N]
//     req_b      NREQ*N  operand B, packed like req_a
//     req_sub    NREQ    1 = A-B, 0 = A+B
//     rsp_valid  1       response register holds a result
//     rsp_ready  1       consumer takes the response this cycle
//     rsp_id     IW      requester that issued the operation
//     rsp_result N       adder sum
//     rsp_cout   1       adder carry out (sub: 1 = no borrow)
//     rsp_zero   1       result == 0
//     rsp_neg    1       result MSB
//     rsp_ovf    1       signed overflow
//   Modports: master = requesters plus response consumer, slave = arbiter.
interface addsub_share_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 2
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [N-1:0]      rsp_result;
  logic              rsp_cout;
  logic              rsp_zero;
  logic              rsp_neg;
  logic              rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_cout,
           rsp_zero, rsp_neg, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_cout,
           rsp_zero, rsp_neg, rsp_ovf
  );
endinterface

// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter
//   Shares one ripple add/sub slice between NREQ requesters using
//   round-robin arbitration. The granted operation is computed in the grant
//   cycle and registered, together with its flags and requester ID, into a
//   single response register (1-cycle latency, full throughput because the
//   register may drain and refill in the same cycle).
//   Ports:
//     clk          rising-edge clock
//     rst_n        synchronous reset, active low
//     bus          addsub_share_arbiter_if slave modport (request/response)
//     dbg_state_o  response FSM state (0 = EMPTY, 1 = FULL)
module addsub_share_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  addsub_share_arbiter_if.slave  bus,
  output logic [0:0]             dbg_state_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;

  logic          can_accept;
  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_idx;

  logic [N-1:0]  a_sel, b_sel;
  logic          sub_sel;
  logic [N-1:0]  sum;
  logic          carry;
  logic          b_eff;
  logic          ovf;

  // The response register can take a new result if it is empty or is being
  // drained this very cycle.
  assign can_accept = (state_q == ST_EMPTY) | bus.rsp_ready;

  // Round-robin scan starting at ptr. The sum is one bit wider than the
  // pointer so the wrap works for any NREQ, not only powers of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NREQ)) scan_sum = scan_sum - (IW+1)'(NREQ);
      scan_idx = scan_sum[IW-1:0];
      if (!grant_vld && bus.req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (!rst_n || !can_accept) grant_vld = 1'b0;
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_vld) bus.req_ready[grant_idx] = 1'b1;
  end

  // Operand mux from the granted requester.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IW'(i)) begin
        a_sel   = bus.req_a[i*N +: N];
        b_sel   = bus.req_b[i*N +: N];
        sub_sel = bus.req_sub[i];
      end
    end
  end

  // Ripple add/sub slice: subtraction is A + ~B + 1, so D doubles as the
  // carry-in and the B inverter control.
  always_comb begin
    sum   = '0;
    b_eff = 1'b0;
    carry = sub_sel;
    for (int i = 0; i < N; i++) begin
      b_eff  = b_sel[i] ^ sub_sel;
      sum[i] = a_sel[i] ^ b_eff ^ carry;
      carry  = (a_sel[i] & b_eff) | (carry & (a_sel[i] ^ b_eff));
    end
  end

  always_comb begin
    if (sub_sel)
      ovf = (a_sel[N-1] != b_sel[N-1]) & (sum[N-1] != a_sel[N-1]);
    else
      ovf = (a_sel[N-1] == b_sel[N-1]) & (sum[N-1] != a_sel[N-1]);
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    if (grant_vld) begin
      state_d  = ST_FULL;
      ptr_d    = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + IW'(1);
      id_d     = grant_idx;
      result_d = sum;
      cout_d   = carry;
      zero_d   = (sum == '0);
      neg_d    = sum[N-1];
      ovf_d    = ovf;
    end else if (bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      id_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.rsp_valid  = (state_q == ST_FULL);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_neg    = neg_q;
  assign bus.rsp_ovf    = ovf_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_addsub_share_arbiter.sv
// tb_addsub_share_arbiter
//   Bench for addsub_share_arbiter (N=4, NREQ=2). The driver applies one
//   stimulus vector per cycle, predicts the grant from a round-robin model
//   and pushes the expected response into exp_q; a monitor pops and compares
//   whenever the DUT presents a response.
module tb_addsub_share_arbiter;
  localparam int N    = 4;
  localparam int NREQ = 2;
  localparam int IW   = 1;
  localparam int RW   = IW + N + 4;

  logic       clk;
  logic       rst_n;
  logic [0:0] dbg_state;

  addsub_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  addsub_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  int  m_ptr    = 0;
  bit  m_full   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [RW-1:0] ref_op(input int id, input int a,
                                           input int b, input bit sub);
    int mod, full, res, sa, sb, exact;
    bit cout, ovf;
    mod = 1 << N;
    if (sub) begin
      full = a - b + mod;
      cout = (a >= b);
    end else begin
      full = a + b;
      cout = (full >= mod);
    end
    res   = full % mod;
    sa    = (a >= mod/2) ? a - mod : a;
    sb    = (b >= mod/2) ? b - mod : b;
    exact = sub ? sa - sb : sa + sb;
    ovf   = (exact > mod/2 - 1) || (exact < -(mod/2));
    return {IW'(id), N'(res), cout, (res == 0), (res >= mod/2), ovf};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rst_v, input logic [NREQ-1:0] v,
                      input logic [NREQ*N-1:0] a, input logic [NREQ*N-1:0] b,
                      input logic [NREQ-1:0] sub, input bit rr);
    int g, idx;
    logic [NREQ-1:0] exp_rdy;
    @(posedge clk);
    #1;
    rst_n         = rst_v;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = sub;
    bus.rsp_ready = rr;
    @(negedge clk);
    #1;
    g = -1;
    if (rst_v && (!m_full || rr)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", bus.req_ready, exp_rdy);
    if (!rst_v) begin
      exp_q.delete();
      m_ptr  = 0;
      m_full = 1'b0;
    end else if (g >= 0) begin
      exp_q.push_back(ref_op(g, int'(a[g*N +: N]), int'(b[g*N +: N]), sub[g]));
      m_ptr  = (g + 1) % NREQ;
      m_full = 1'b1;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, '0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("rsp_valid", bus.rsp_valid, exp_q.size() != 0);
      if (bus.rsp_valid && exp_q.size() != 0) begin
        check("rsp_fields", {bus.rsp_id, bus.rsp_result, bus.rsp_cout,
                             bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}, exp_q[0]);
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b0;

    // Reset with requests pending: no grant while in reset.
    step(1'b0, 2'b11, 8'h12, 8'h34, 2'b00, 1'b1);
    step(1'b0, 2'b11, 8'h12, 8'h34, 2'b00, 1'b1);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_fields", {bus.rsp_id, bus.rsp_result, bus.rsp_cout,
                               bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}, 0);
    check("reset_state", dbg_state, 1'b0);
    mon_en = 1'b1;

    // Single add 3+5 on requester 0.
    step(1'b1, 2'b01, {4'd0, 4'd3}, {4'd0, 4'd5}, 2'b00, 1'b1);
    idle(1);

    // Sub to zero and borrow case on requester 1.
    step(1'b1, 2'b10, {4'd5, 4'd0}, {4'd5, 4'd0}, 2'b10, 1'b1);
    step(1'b1, 2'b10, {4'd2, 4'd0}, {4'd3, 4'd0}, 2'b10, 1'b1);
    idle(1);

    // Contention after a fresh reset: grants alternate 0,1,0,1,...
    step(1'b0, 2'b00, '0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b1, 2'b11, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1);
    idle(1);

    // Backpressure: fill, stall three cycles, then drain+refill together.
    step(1'b1, 2'b11, 8'h73, 8'h21, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'b11, 8'h73, 8'h21, 2'b01, 1'b0);
    step(1'b1, 2'b11, 8'h73, 8'h21, 2'b01, 1'b1);
    idle(1);

    // Signed subtract overflow: -8 - 1.
    step(1'b1, 2'b01, {4'd0, 4'd8}, {4'd0, 4'd1}, 2'b01, 1'b1);
    idle(1);

    // Reset mid-operation with a held response and ptr at 1.
    step(1'b1, 2'b01, {4'd0, 4'd6}, {4'd0, 4'd2}, 2'b00, 1'b0);
    step(1'b0, 2'b11, 8'h44, 8'h11, 2'b00, 1'b0);
    step(1'b1, 2'b11, 8'h9a, 8'h5c, 2'b10, 1'b1);
    idle(1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      step(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
           $urandom_range(0, 3) != 0);

    idle(3);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
